// File: rtl/keylock_param.sv
// Parametrised digit-sequence lock with failed-attempt lockout and alarm.
// Define KEYLOCK_PROG_EN to allow reprogramming the code while unlocked.
module keylock_param #(
    parameter int                         DIGIT_W        = 4,
    parameter int                         CODE_LEN       = 6,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE  = {4'd6, 4'd5, 4'd2, 4'd5, 4'd3, 4'd3},
    parameter int                         MAX_FAILS      = 3,
    parameter int                         LOCKOUT_CYCLES = 16,
    localparam int                        FW             = $clog2(MAX_FAILS + 1),
    localparam int                        IW             = $clog2(CODE_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key,
    input  logic               relock,
    input  logic               prog_en,
    output logic               locked,
    output logic               alarm,
    output logic [FW-1:0]      fail_cnt,
    output logic [IW-1:0]      digit_idx
);
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int CW = CODE_LEN * DIGIT_W;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2,
        PROGRAM  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [FW-1:0]      fail_q, fail_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [CW-1:0]      code_w;
    logic [DIGIT_W-1:0] exp_digit;
    logic [FW-1:0]      fail_inc;

`ifdef KEYLOCK_PROG_EN
    logic [CW-1:0] code_q, code_d, shadow_q, shadow_d;
    assign code_w = code_q;
`else
    assign code_w = DEFAULT_CODE;
`endif

    assign fail_inc = fail_q + 1'b1;

    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < CODE_LEN; i++)
            if (idx_q == IW'(i)) exp_digit = code_w[i*DIGIT_W +: DIGIT_W];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fail_d  = fail_q;
        timer_d = timer_q;
`ifdef KEYLOCK_PROG_EN
        code_d   = code_q;
        shadow_d = shadow_q;
`endif
        case (state_q)
            ENTRY: begin
                if (key_valid) begin
                    if (key == exp_digit) begin
                        if (idx_q == IW'(CODE_LEN - 1)) begin
                            state_d = UNLOCKED;
                            idx_d   = '0;
                            fail_d  = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        // Bad digit restarts the attempt; it is not retried as digit 0.
                        idx_d  = '0;
                        fail_d = fail_inc;
                        if (fail_inc == FW'(MAX_FAILS)) begin
                            state_d = LOCKOUT;
                            timer_d = TW'(LOCKOUT_CYCLES);
                        end
                    end
                end
            end
            LOCKOUT: begin
                timer_d = timer_q - 1'b1;
                if (timer_q == TW'(1)) begin
                    state_d = ENTRY;
                    fail_d  = '0;
                    idx_d   = '0;
                end
            end
            UNLOCKED: begin
                if (relock) begin
                    state_d = ENTRY;
                end else if (prog_en) begin
`ifdef KEYLOCK_PROG_EN
                    state_d = PROGRAM;
                    idx_d   = '0;
`else
                    state_d = UNLOCKED;
`endif
                end
            end
`ifdef KEYLOCK_PROG_EN
            PROGRAM: begin
                if (relock) begin
                    state_d = ENTRY;
                    idx_d   = '0;
                end else if (key_valid) begin
                    for (int i = 0; i < CODE_LEN; i++)
                        if (idx_q == IW'(i)) shadow_d[i*DIGIT_W +: DIGIT_W] = key;
                    if (idx_q == IW'(CODE_LEN - 1)) begin
                        code_d  = shadow_d;
                        state_d = ENTRY;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = ENTRY;
                idx_d   = '0;
                fail_d  = '0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ENTRY;
            idx_q    <= '0;
            fail_q   <= '0;
            timer_q  <= '0;
`ifdef KEYLOCK_PROG_EN
            code_q   <= DEFAULT_CODE;
            shadow_q <= DEFAULT_CODE;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fail_q   <= fail_d;
            timer_q  <= timer_d;
`ifdef KEYLOCK_PROG_EN
            code_q   <= code_d;
            shadow_q <= shadow_d;
`endif
        end
    end

    assign locked    = !(state_q == UNLOCKED || state_q == PROGRAM);
    assign alarm     = (state_q == LOCKOUT);
    assign fail_cnt  = fail_q;
    assign digit_idx = idx_q;
endmodule

// File: tb/tb_keylock_param.sv
// Directed bench for keylock_param: entry, failures, lockout timing, async reset, reprogramming.
module tb_keylock_param;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic       relock = 1'b0;
    logic       prog_en = 1'b0;
    logic       locked, alarm;
    logic [1:0] fail_cnt;
    logic [2:0] digit_idx;

    int nvec = 0;
    int nerr = 0;
    int dflt [6] = '{3, 3, 5, 2, 5, 6};
    int ncode[6] = '{1, 2, 3, 4, 5, 6};

    keylock_param dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key(key),
        .relock(relock), .prog_en(prog_en), .locked(locked), .alarm(alarm),
        .fail_cnt(fail_cnt), .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present a digit for one rising edge; returns at the following falling edge.
    task automatic strobe(input int d);
        @(negedge clk);
        key_valid = 1'b1;
        key = 4'(d);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic pulse_relock();
        @(negedge clk);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
    endtask

    task automatic enter_default();
        for (int i = 0; i < 6; i++) strobe(dflt[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int acnt;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: reset state and correct code
        chk("rst_locked", locked, 1);
        chk("rst_alarm", alarm, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_idx", digit_idx, 0);
        for (int i = 0; i < 5; i++) begin
            strobe(dflt[i]);
            chk($sformatf("t1_idx%0d", i + 1), digit_idx, i + 1);
            chk("t1_still_locked", locked, 1);
        end
        strobe(dflt[5]);
        chk("t1_unlocked", locked, 0);
        chk("t1_idx_wrap", digit_idx, 0);
        chk("t1_fail", fail_cnt, 0);

        // 2: one failure then success clears fail_cnt
        pulse_relock();
        chk("t2_relocked", locked, 1);
        strobe(3); strobe(3); strobe(7);
        chk("t2_idx", digit_idx, 0);
        chk("t2_fail", fail_cnt, 1);
        enter_default();
        chk("t2_unlocked", locked, 0);
        chk("t2_fail_clr", fail_cnt, 0);
        strobe(9);
        chk("t2_keys_ignored_open", locked, 0);
        pulse_relock();
        chk("t2_relock", locked, 1);

        // 3: lockout lasts exactly 16 cycles and ignores keys
        strobe(9); strobe(9);
        chk("t3_fail2", fail_cnt, 2);
        chk("t3_no_alarm_yet", alarm, 0);
        strobe(9);
        chk("t3_alarm_on", alarm, 1);
        chk("t3_fail3", fail_cnt, 3);
        acnt = 1;
        for (int i = 0; i < 40; i++) begin
            if (i < 6) begin
                key_valid = 1'b1;
                key = 4'(dflt[i]);
            end
            relock = (i == 8);
            @(negedge clk);
            key_valid = 1'b0;
            relock = 1'b0;
            if (alarm) acnt++;
        end
        chk("t3_alarm_cycles", acnt, 16);
        chk("t3_locked_after", locked, 1);
        chk("t3_alarm_off", alarm, 0);
        chk("t3_fail_clr", fail_cnt, 0);
        chk("t3_idx_clr", digit_idx, 0);
        enter_default();
        chk("t3_unlock", locked, 0);
        pulse_relock();

        // 4: idle key_valid=0 cycles, async reset mid-sequence
        strobe(3); strobe(3);
        key = 4'd3;
        repeat (10) @(negedge clk);
        chk("t4_idle_idx", digit_idx, 2);
        chk("t4_idle_fail", fail_cnt, 0);
        strobe(5); strobe(2);
        chk("t4_idx4", digit_idx, 4);
        #2 reset = 1'b1;
        #1;
        chk("t4_async_idx", digit_idx, 0);
        chk("t4_async_locked", locked, 1);
        @(negedge clk);
        reset = 1'b0;
        enter_default();
        chk("t4_unlock", locked, 0);
        pulse_relock();

`ifdef KEYLOCK_PROG_EN
        // 5: reprogram to 1..6
        enter_default();
        @(negedge clk); prog_en = 1'b1;
        @(negedge clk); prog_en = 1'b0;
        chk("t5_prog_open", locked, 0);
        for (int i = 0; i < 6; i++) strobe(ncode[i]);
        chk("t5_prog_done", locked, 1);
        chk("t5_prog_idx", digit_idx, 0);
        strobe(3);
        chk("t5_old_fails", fail_cnt, 1);
        for (int i = 0; i < 6; i++) strobe(ncode[i]);
        chk("t5_new_unlocks", locked, 0);
        do_reset();
        enter_default();
        chk("t5_default_back", locked, 0);
        pulse_relock();

        // 6: aborted programming keeps the code
        enter_default();
        @(negedge clk); prog_en = 1'b1;
        @(negedge clk); prog_en = 1'b0;
        strobe(1); strobe(2);
        pulse_relock();
        chk("t6_abort_locked", locked, 1);
        enter_default();
        chk("t6_code_kept", locked, 0);
        pulse_relock();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/keylock_param.md
Name: keylock_param

Overview:
Parametrised digit-sequence lock. Accepts one digit per key_valid strobe and compares it against a stored CODE_LEN-digit code. Opens when the full sequence matches and stays open until explicitly relocked. Counts consecutive failed attempts and enters a timed lockout with an alarm after MAX_FAILS failures. Sits between a keypad scanner/debouncer and the door actuator/status logic.

Parameters:
DIGIT_W, 4, width of one key digit in bits
CODE_LEN, 6, number of digits in the code (>=2)
DEFAULT_CODE, {4'd6,4'd5,4'd2,4'd5,4'd3,4'd3}, CODE_LEN*DIGIT_W bits; digit 0 in LSBs (default sequence 3,3,5,2,5,6)
MAX_FAILS, 3, failed attempts that trigger lockout (>=1)
LOCKOUT_CYCLES, 16, lockout duration in clk cycles (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
key_valid  input  1  one-cycle strobe: key holds a digit this cycle
key  input  DIGIT_W  digit value, sampled only when key_valid=1
relock  input  1  return to locked entry state from UNLOCKED/PROGRAM
prog_en  input  1  request code reprogramming (only with KEYLOCK_PROG_EN)
locked  output  1  1 = locked
alarm  output  1  1 = lockout in progress
fail_cnt  output  $clog2(MAX_FAILS+1)  consecutive failed attempts
digit_idx  output  $clog2(CODE_LEN)  index of next expected digit

Behaviour:
- Reset (async): state=ENTRY, digit_idx=0, fail_cnt=0, lockout timer=0, code=DEFAULT_CODE, locked=1, alarm=0.
- Moore outputs, decoded from registered state: locked=0 in UNLOCKED and PROGRAM, otherwise 1. alarm=1 only in LOCKOUT.
- Cycles with key_valid=0 never change state, digit_idx or fail_cnt. Any DIGIT_W value is legal.
- ENTRY, key_valid=1:
  - key==code[digit_idx] and digit_idx<CODE_LEN-1: digit_idx+1.
  - key==code[CODE_LEN-1] and digit_idx==CODE_LEN-1: go to UNLOCKED, digit_idx=0, fail_cnt=0. locked reads 0 the cycle after the accepting edge.
  - Mismatch: digit_idx=0. The mismatching digit is NOT re-evaluated as digit 0. fail_cnt+1.
  - If the incremented fail_cnt equals MAX_FAILS: go to LOCKOUT, load timer=LOCKOUT_CYCLES.
- LOCKOUT:
  - key_valid and relock are ignored.
  - Timer decrements every cycle.
  - When timer==1 at a clock edge: go to ENTRY, fail_cnt=0, digit_idx=0.
  - alarm is high for exactly LOCKOUT_CYCLES cycles.
- UNLOCKED:
  - Stays open indefinitely; key_valid is ignored.
  - relock=1: go to ENTRY next edge.
  - relock and prog_en both high: relock wins.
- Reset mid-sequence or mid-lockout: immediate return to reset values. Lockout is not preserved across reset.
- Unused state encodings recover to ENTRY.

Optional Feature:
Macro KEYLOCK_PROG_EN.
- Defined:
  - In UNLOCKED, prog_en=1 (with relock=0) enters PROGRAM, digit_idx=0.
  - Each key_valid writes key into shadow[digit_idx] and increments digit_idx.
  - The CODE_LEN-th digit copies shadow into code (whole code updated atomically) and goes to ENTRY with locked=1.
  - relock during PROGRAM aborts: code unchanged, go to ENTRY.
  - A digit and relock in the same cycle: relock wins, digit discarded.
  - Reset restores DEFAULT_CODE.
- Not defined: no PROGRAM state or shadow register; prog_en is ignored; code is the constant DEFAULT_CODE.

Test Plan:
1. Reset, then strobe 3,3,5,2,5,6 -> digit_idx 0..5; locked=0 the cycle after the 6th strobe; fail_cnt=0.
2. Strobe 3,3,7 -> digit_idx=0, fail_cnt=1. Then strobe 3,3,5,2,5,6 -> unlock, fail_cnt=0. Assert relock -> locked=1 next cycle.
3. Three wrong digits (9,9,9) -> alarm=1 for exactly 16 cycles. During lockout, 3,3,5,2,5,6 are ignored. Afterwards fail_cnt=0, alarm=0, and the correct code unlocks.
4. Drive key=3 with key_valid=0 for 10 cycles -> no change. Assert reset mid-sequence (digit_idx=4) -> digit_idx=0, locked=1 immediately, without waiting for a clock edge.
5. (KEYLOCK_PROG_EN) Unlock, prog_en, enter 1,2,3,4,5,6 -> locked=1. Old code fails. 1,2,3,4,5,6 unlocks. Reset -> 3,3,5,2,5,6 unlocks again.
6. (KEYLOCK_PROG_EN) Unlock, prog_en, enter 1,2, then relock -> code unchanged; 3,3,5,2,5,6 still unlocks.
